hebb_trainer: RTL

Sequential Hebbian weight trainer for the 25-neuron Hopfield recall engine. Holds up to P training patterns (5×5 bitmaps, bit index = row*5+col), then streams all N×N signed link weights into the recall engine's weight store, one weight per clock, through a simple write port. It replaces a single-cycle fully unrolled weight computation with a small counter-driven datapath, sitting directly upstream of the recall stage.

---
 rtl/neuro_pkg.sv | 33 +++
 rtl/hebb_trainer_if.sv | 24 ++
 rtl/hebb_trainer_term.sv | 22 ++
 rtl/hebb_trainer.sv | 105 ++++++++++
 4 files changed

// File: rtl/neuro_pkg.sv
// rtl/neuro_pkg.sv - shared constants, FSM state type and pattern constants for the Hebbian trainer
package neuro_pkg;

  localparam int N  = 25;            // neurons per pattern
  localparam int P  = 5;             // pattern slots
  localparam int WW = 4;             // signed weight width
  localparam int AW = 10;            // weight address width
  localparam int SW = 3;             // slot select width
  localparam int KW = $clog2(N);     // neuron index width
  localparam int CW = $clog2(P + 1); // popcount width
  localparam int NN = N * N;         // weights per pass

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 5x5 bitmaps, bit index = row*5+col
  localparam logic [N-1:0] PAT_D = 25'b0111010010100101001001111;
  localparam logic [N-1:0] PAT_C = 25'b0111000001000010000101110;
  localparam logic [N-1:0] PAT_J = 25'b0011001001010000100011100;
  localparam logic [N-1:0] PAT_M = 25'b1000110001101011101110001;

  // number of set bits in a P-bit column difference
  function automatic logic [CW-1:0] popcount(input logic [P-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < P; i++) c = c + CW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/hebb_trainer_if.sv
// rtl/hebb_trainer_if.sv - pattern load, control and weight write port bundle
interface hebb_trainer_if
  import neuro_pkg::*;
  ;
  logic                 pat_we;
  logic [SW-1:0]        pat_sel;
  logic [N-1:0]         pat_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic signed [WW-1:0] w_data;

  modport master (
    output pat_we, pat_sel, pat_data, start,
    input  busy, done, w_we, w_addr, w_data
  );

  modport slave (
    input  pat_we, pat_sel, pat_data, start,
    output busy, done, w_we, w_addr, w_data
  );
endinterface

// File: rtl/hebb_trainer_term.sv
// rtl/hebb_trainer_term.sv - one Hebbian link weight from two slot columns
module hebb_term
  import neuro_pkg::*;
#(
  parameter bit ZERO_DIAG = 1'b0
) (
  input  logic [P-1:0]         col_k,
  input  logic [P-1:0]         col_m,
  input  logic                 diag,
  output logic signed [WW-1:0] weight
);

  logic [CW-1:0] diff;

  // agreements minus disagreements = P - 2*disagreements
  always_comb begin
    diff   = popcount(col_k ^ col_m);
    weight = WW'(P - 2 * int'(diff));
    if (ZERO_DIAG && diag) weight = '0;
  end

endmodule

// File: rtl/hebb_trainer.sv
// rtl/hebb_trainer.sv - counter-driven Hebbian trainer streaming N*N weights to the recall store
module hebb_trainer
  import neuro_pkg::*;
#(
  parameter bit ZERO_DIAG = 1'b0
) (
  input logic           clk,
  input logic           rst,
  hebb_trainer_if.slave bus
);

  logic [N-1:0]         slots [P];
  state_t               state;
  logic [KW-1:0]        k;
  logic [KW-1:0]        m;
  logic [AW-1:0]        addr;
  logic [P-1:0]         col_k;
  logic [P-1:0]         col_m;
  logic signed [WW-1:0] term;

  // gather bit k and bit m of every slot into P-bit columns
  always_comb begin
    col_k = '0;
    col_m = '0;
    for (int p = 0; p < P; p++) begin
      col_k[p] = slots[p][k];
      col_m[p] = slots[p][m];
    end
  end

  hebb_term #(.ZERO_DIAG(ZERO_DIAG)) u_term (
    .col_k  (col_k),
    .col_m  (col_m),
    .diag   (k == m),
    .weight (term)
  );

  // pattern slots: writable only while idle, out-of-range selects dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < P; p++) slots[p] <= '0;
    end else if (bus.pat_we && state == IDLE && bus.pat_sel < SW'(P)) begin
      slots[bus.pat_sel] <= bus.pat_data;
    end
  end

  // pass sequencer: one registered weight write per RUN cycle, then a done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      k          <= '0;
      m          <= '0;
      addr       <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.w_we   <= 1'b0;
      bus.w_addr <= '0;
      bus.w_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          bus.w_we <= 1'b0;
          if (bus.start) begin
            state <= RUN;
            k     <= '0;
            m     <= '0;
            addr  <= '0;
          end
        end
        RUN: begin
          bus.busy   <= 1'b1;
          bus.w_we   <= 1'b1;
          bus.w_addr <= addr;
          bus.w_data <= term;
          addr       <= addr + 1'b1;
          if (addr == AW'(NN - 1)) begin
            state <= DONE;
            k     <= '0;
            m     <= '0;
          end else if (m == KW'(N - 1)) begin
            m <= '0;
            k <= k + 1'b1;
          end else begin
            m <= m + 1'b1;
          end
        end
        DONE: begin
          // stay here through the done cycle so a start seen with done high is dropped
          bus.busy <= 1'b0;
          bus.w_we <= 1'b0;
          if (!bus.done) begin
            bus.done <= 1'b1;
          end else begin
            bus.done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
